// File: rtl/apb_bridge_pkg.sv
// Shared state encoding and address-map constants for the AHB-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } bridge_state_t;

  localparam int unsigned APB_WIN_SHIFT          = 12;
  localparam logic [31:0] DEFAULT_APB_BASE       = 32'h4000_D000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/apb_psel_decoder.sv
// Maps a byte address onto one of NUM_PSEL 4 KB peripheral windows above APB_BASE.
module apb_psel_decoder
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_PSEL = 4,
  parameter logic [31:0] APB_BASE = DEFAULT_APB_BASE,
  parameter int unsigned IDX_W    = 2
) (
  input  logic [31:0]         addr,
  output logic [IDX_W-1:0]    idx,
  output logic [NUM_PSEL-1:0] onehot,
  output logic                valid
);

  localparam int unsigned WIN_W = 32 - APB_WIN_SHIFT;

  logic [WIN_W-1:0] win;

  // Addresses below the base wrap around on subtraction, so they are rejected explicitly.
  always_comb begin
    win    = WIN_W'((addr - APB_BASE) >> APB_WIN_SHIFT);
    valid  = (addr >= APB_BASE) && (win < WIN_W'(NUM_PSEL));
    idx    = win[IDX_W-1:0];
    onehot = '0;
    for (int i = 0; i < int'(NUM_PSEL); i++) begin
      onehot[i] = valid && (win == WIN_W'(i));
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// Converts single-beat AHB-side accesses into APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module ahb2apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_PSEL = 4,
  parameter logic [31:0] APB_BASE = DEFAULT_APB_BASE
`ifdef APB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hsel_i,
  input  logic [31:0]            haddr_i,
  input  logic [31:0]            hwdata_i,
  input  logic                   hwe_i,
  output logic [31:0]            hrdata_o,
  output logic                   hready_o,
  output logic                   herr_o,
  output logic [31:0]            paddr_o,
  output logic [31:0]            pwdata_o,
  output logic                   pwrite_o,
  output logic [NUM_PSEL-1:0]    psel_o,
  output logic                   penable_o,
  input  logic [32*NUM_PSEL-1:0] prdata_i,
  input  logic [NUM_PSEL-1:0]    pready_i,
  input  logic [NUM_PSEL-1:0]    pslverr_i
);

  localparam int unsigned IDX_W = (NUM_PSEL > 1) ? $clog2(NUM_PSEL) : 1;

  bridge_state_t state_q, state_d;

  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                write_q;
  logic                err_q;
  logic [31:0]         dec_addr;
  logic [IDX_W-1:0]    dec_idx;
  logic [NUM_PSEL-1:0] dec_onehot;
  logic                dec_valid;
  logic                sel_ready;
  logic                sel_slverr;
  logic [31:0]         sel_rdata;
  logic                timeout_hit;

  // One decoder serves both the IDLE capture and the select drive for the held address.
  assign dec_addr = (state_q == IDLE) ? haddr_i : addr_q;

  apb_psel_decoder #(
    .NUM_PSEL (NUM_PSEL),
    .APB_BASE (APB_BASE),
    .IDX_W    (IDX_W)
  ) u_decoder (
    .addr   (dec_addr),
    .idx    (dec_idx),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  assign sel_ready  = pready_i[dec_idx];
  assign sel_slverr = pslverr_i[dec_idx];
  assign sel_rdata  = prdata_i[32*dec_idx +: 32];

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && !sel_ready) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ACCESS) && !sel_ready &&
                       (wait_cnt_q + 1'b1 == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // Out-of-range requests spend a dead SETUP cycle with no select so the error answers 2 cycles after the request.
  always_comb begin
    state_d   = state_q;
    psel_o    = '0;
    penable_o = 1'b0;
    hready_o  = 1'b0;
    herr_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hsel_i) state_d = SETUP;
      end
      SETUP: begin
        psel_o  = dec_onehot;
        state_d = err_q ? DONE : ACCESS;
      end
      ACCESS: begin
        psel_o    = dec_onehot;
        penable_o = 1'b1;
        if (sel_ready || timeout_hit) state_d = DONE;
      end
      DONE: begin
        hready_o = 1'b1;
        herr_o   = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (hsel_i) begin
            addr_q  <= haddr_i;
            wdata_q <= hwdata_i;
            write_q <= hwe_i;
            err_q   <= !dec_valid;
          end
        end
        SETUP: begin
          if (err_q) rdata_q <= '0;
        end
        ACCESS: begin
          if (sel_ready) begin
            rdata_q <= write_q ? '0 : sel_rdata;
            err_q   <= sel_slverr;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign paddr_o  = addr_q;
  assign pwdata_o = wdata_q;
  assign pwrite_o = write_q;
  assign hrdata_o = rdata_q;

endmodule
